rf_access_ctrl: RTL and testbench

Sequencing initiator for the single-port 16-bit, 8-entry register file. It accepts operand-read and write-back requests from the CPU control path over a valid/ready handshake. It serializes each request into register-file port cycles (`reg_num`, `rd_wr`, data) and returns captured operands over a valid/ready response channel. It guarantees `reg_num` never changes while `rd_wr` is high, because the register file writes level-sensitively.

---
 rtl/rf_access_ctrl_if.sv | 41 ++++
 rtl/rf_access_ctrl.sv | 150 +++++++++++++++
 tb/tb_rf_access_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_access_ctrl_if.sv
// Bundle between the CPU control path, the access controller and the
// single-port 16-bit x 8 register file.
//
// Both req_* and rsp_* are valid/ready channels: the producer raises valid
// with stable payload and keeps both unchanged until it samples ready high
// on a rising edge; a transfer happens on exactly that edge
// (valid & ready), and ready never waits on anything but the consumer's
// own state.
interface rf_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [2:0]  req_rx;
    logic [2:0]  req_ry;
    logic [15:0] req_data;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_a;
    logic [15:0] rsp_b;
    logic        rsp_err;

    logic [2:0]  rf_reg_num;
    logic        rf_rd_wr;
    logic [15:0] rf_wdata;
    logic [15:0] rf_rdata;

    // Controller side: consumes requests, produces responses, drives the RF.
    modport slave (
        input  req_valid, req_op, req_rx, req_ry, req_data, rsp_ready, rf_rdata,
        output req_ready, rsp_valid, rsp_a, rsp_b, rsp_err,
        output rf_reg_num, rf_rd_wr, rf_wdata
    );

    // Environment side: CPU control path plus the register file itself.
    modport master (
        output req_valid, req_op, req_rx, req_ry, req_data, rsp_ready, rf_rdata,
        input  req_ready, rsp_valid, rsp_a, rsp_b, rsp_err,
        input  rf_reg_num, rf_rd_wr, rf_wdata
    );
endinterface

// File: rtl/rf_access_ctrl.sv
// Register-file access sequencer: turns one read/dual-read/write request
// into RF port cycles and returns the captured operands. The RF writes
// level-sensitively, so rf_reg_num is never moved while rf_rd_wr is high,
// including across reset.
module rf_access_ctrl (
    input  logic             clk,
    input  logic             reset,
    rf_access_ctrl_if.slave  bus,
    output logic [2:0]       o_dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RDA   = 3'd1,
        S_RDB   = 3'd2,
        S_WR    = 3'd3,
        S_WHOLD = 3'd4,
        S_RSP   = 3'd5
    } state_t;

    localparam logic [1:0] OP_RD1 = 2'b00;
    localparam logic [1:0] OP_RD2 = 2'b01;
    localparam logic [1:0] OP_WR  = 2'b10;

    state_t      r_state;
    state_t      w_next;

    logic [1:0]  r_op;
    logic [2:0]  r_ry;
    logic [15:0] r_data;
    logic [2:0]  r_reg_num;
    logic        r_rd_wr;
    logic [15:0] r_wdata;
    logic [15:0] r_rsp_a;
    logic [15:0] r_rsp_b;
    logic        r_rsp_err;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; every non-idle state except RSP advances unconditionally.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    case (bus.req_op)
                        OP_RD1, OP_RD2: w_next = S_RDA;
                        OP_WR:          w_next = S_WR;
                        default:        w_next = S_RSP;
                    endcase
                end
            end
            S_RDA:   w_next = (r_op == OP_RD2) ? S_RDB : S_RSP;
            S_RDB:   w_next = S_RSP;
            S_WR:    w_next = S_WHOLD;
            S_WHOLD: w_next = S_RSP;
            S_RSP:   w_next = bus.rsp_ready ? S_IDLE : S_RSP;
            default: w_next = S_IDLE;
        endcase
    end

    // Request latch, RF port registers and response capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op      <= OP_RD1;
            r_ry      <= 3'd0;
            r_data    <= 16'd0;
            r_rd_wr   <= 1'b0;
            r_wdata   <= 16'd0;
            r_rsp_a   <= 16'd0;
            r_rsp_b   <= 16'd0;
            r_rsp_err <= 1'b0;
            // A write may be in progress: keep the index for this edge and
            // clear it on the next one, once rf_rd_wr has dropped.
            if (!r_rd_wr) begin
                r_reg_num <= 3'd0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_op   <= bus.req_op;
                        r_ry   <= bus.req_ry;
                        r_data <= bus.req_data;
                        case (bus.req_op)
                            OP_RD1, OP_RD2: begin
                                r_reg_num <= bus.req_rx;
                                r_rd_wr   <= 1'b0;
                            end
                            OP_WR: begin
                                r_reg_num <= bus.req_rx;
                                r_wdata   <= bus.req_data;
                                r_rd_wr   <= 1'b1;
                            end
                            default: begin
                                r_rsp_err <= 1'b1;
                                r_rsp_a   <= 16'd0;
                                r_rsp_b   <= 16'd0;
                            end
                        endcase
                    end
                end
                S_RDA: begin
                    r_rsp_a <= bus.rf_rdata;
                    if (r_op == OP_RD2) begin
                        r_reg_num <= r_ry;
                    end else begin
                        r_rsp_b <= 16'd0;
                    end
                end
                S_RDB: begin
                    r_rsp_b <= bus.rf_rdata;
                end
                S_WR: begin
                    // Index stays put through WHOLD so the RF sees a clean
                    // write-enable fall with a stable address.
                    r_rd_wr <= 1'b0;
                end
                S_WHOLD: begin
                    r_rsp_a <= r_data;
                    r_rsp_b <= 16'd0;
                end
                S_RSP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_err <= 1'b0;
                    end
                end
                default: begin
                    r_rd_wr <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.rsp_valid  = (r_state == S_RSP);
    assign bus.rsp_a      = r_rsp_a;
    assign bus.rsp_b      = r_rsp_b;
    assign bus.rsp_err    = r_rsp_err;
    assign bus.rf_reg_num = r_reg_num;
    assign bus.rf_rd_wr   = r_rd_wr;
    assign bus.rf_wdata   = r_wdata;
    assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_rf_access_ctrl.sv
// Bench for rf_access_ctrl: a behavioural register file, a request driver
// and a response monitor working from expectation queues.
module tb_rf_access_ctrl;
    logic clk = 1'b0;
    logic reset;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    rf_access_ctrl_if bus ();

    rf_access_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // Register file: combinational read, write while rd_wr is high.
    logic [15:0] rf_mem [8];
    assign bus.rf_rdata = rf_mem[bus.rf_reg_num];
    always @(posedge clk) begin
        if (bus.rf_rd_wr) rf_mem[bus.rf_reg_num] <= bus.rf_wdata;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc++;

    logic [32:0] exp_q[$];      // {err, a, b}
    int          exp_lat_q[$];
    logic [18:0] wr_q[$];       // {reg_num, wdata}

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitor: response scoreboard, latency, hold stability and RF invariants.
    int          outstanding = 0;
    int          acc_cyc     = 0;
    logic        p_rd_wr     = 1'b0;
    logic [2:0]  p_reg_num   = 3'd0;
    logic        p_rsp_valid = 1'b0;
    logic [32:0] p_rsp       = '0;

    always @(negedge clk) begin
        if (p_rd_wr) begin
            chk("reg_num_hold_while_write", {61'd0, bus.rf_reg_num}, {61'd0, p_reg_num});
            chk("rd_wr_single_cycle", {63'd0, bus.rf_rd_wr}, 64'd0);
        end
        if (reset) begin
            outstanding = 0;
            exp_q.delete();
            exp_lat_q.delete();
            wr_q.delete();
        end else begin
            if (bus.req_valid && bus.req_ready) begin
                chk("accept_while_busy", outstanding, 0);
                outstanding++;
                acc_cyc = cyc;
            end
            if (bus.rsp_valid && !p_rsp_valid) begin
                if (exp_lat_q.size() == 0) fail_now("rsp_unexpected");
                else chk("rsp_latency", cyc - acc_cyc, exp_lat_q.pop_front());
            end
            if (bus.rsp_valid && p_rsp_valid) begin
                chk("rsp_stable", {bus.rsp_err, bus.rsp_a, bus.rsp_b}, p_rsp);
                chk("req_ready_low_in_rsp", {63'd0, bus.req_ready}, 64'd0);
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) fail_now("rsp_no_expectation");
                else chk("rsp_err_a_b", {bus.rsp_err, bus.rsp_a, bus.rsp_b}, exp_q.pop_front());
                outstanding--;
            end
            if (bus.rf_rd_wr && !p_rd_wr) begin
                if (wr_q.size() == 0) fail_now("rf_write_unexpected");
                else chk("rf_write_idx_data", {bus.rf_reg_num, bus.rf_wdata}, wr_q.pop_front());
            end
        end
        p_rd_wr     = bus.rf_rd_wr;
        p_reg_num   = bus.rf_reg_num;
        p_rsp_valid = bus.rsp_valid;
        p_rsp       = {bus.rsp_err, bus.rsp_a, bus.rsp_b};
    end

    // Driver: present one request and hold it until accepted.
    task automatic send(input logic [1:0] op, input logic [2:0] rx, input logic [2:0] ry,
                        input logic [15:0] data, input logic [15:0] ea, input logic [15:0] eb,
                        input logic ee, input int lat);
        exp_q.push_back({ee, ea, eb});
        exp_lat_q.push_back(lat);
        if (op == 2'b10) wr_q.push_back({rx, data});
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_rx    = rx;
        bus.req_ry    = ry;
        bus.req_data  = data;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (bus.req_ready) break;
        end
        if (!bus.req_ready) fail_now("send_accept_timeout");
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && bus.req_ready) break;
        end
        if (exp_q.size() != 0) fail_now("drain_timeout");
    endtask

    logic [15:0] sh [8];
    logic        rnd_done;

    initial begin
        logic [1:0]  op;
        logic [2:0]  rx;
        logic [2:0]  ry;
        logic [15:0] d;

        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_rx    = 3'd0;
        bus.req_ry    = 3'd0;
        bus.req_data  = 16'd0;
        bus.rsp_ready = 1'b1;
        rnd_done      = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
        chk("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        chk("rst_rsp_a", {48'd0, bus.rsp_a}, 64'd0);
        chk("rst_rsp_b", {48'd0, bus.rsp_b}, 64'd0);
        chk("rst_rsp_err", {63'd0, bus.rsp_err}, 64'd0);
        chk("rst_rd_wr", {63'd0, bus.rf_rd_wr}, 64'd0);
        chk("rst_wdata", {48'd0, bus.rf_wdata}, 64'd0);
        chk("rst_reg_num", {61'd0, bus.rf_reg_num}, 64'd0);
        chk("rst_state", {61'd0, dbg_state}, 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Fill every register with a known pattern.
        for (int i = 0; i < 8; i++) begin
            d = 16'h1000 + 16'(i);
            send(2'b10, 3'(i), 3'd0, d, d, 16'd0, 1'b0, 3);
            sh[i] = d;
        end

        // Write then read back.
        send(2'b10, 3'd3, 3'd0, 16'hBEEF, 16'hBEEF, 16'd0, 1'b0, 3);
        send(2'b00, 3'd3, 3'd0, 16'd0, 16'hBEEF, 16'd0, 1'b0, 2);
        // Dual-operand read.
        send(2'b10, 3'd1, 3'd0, 16'h0011, 16'h0011, 16'd0, 1'b0, 3);
        send(2'b10, 3'd6, 3'd0, 16'hA5A5, 16'hA5A5, 16'd0, 1'b0, 3);
        send(2'b01, 3'd1, 3'd6, 16'd0, 16'h0011, 16'hA5A5, 1'b0, 3);
        send(2'b01, 3'd6, 3'd1, 16'd0, 16'hA5A5, 16'h0011, 1'b0, 3);
        // Reserved op: error response, no RF write.
        send(2'b11, 3'd2, 3'd4, 16'h1234, 16'd0, 16'd0, 1'b1, 1);
        sh[3] = 16'hBEEF; sh[1] = 16'h0011; sh[6] = 16'hA5A5;
        wait_idle();

        // Response backpressure with a second request waiting.
        bus.rsp_ready = 1'b0;
        send(2'b00, 3'd3, 3'd0, 16'd0, 16'hBEEF, 16'd0, 1'b0, 2);
        fork
            send(2'b00, 3'd6, 3'd0, 16'd0, 16'hA5A5, 16'd0, 1'b0, 2);
            begin
                repeat (5) @(posedge clk);
                #1 bus.rsp_ready = 1'b1;
            end
        join
        wait_idle();

        // Reset while the write enable is high.
        @(posedge clk);
        #1;
        wr_q.push_back({3'd5, 16'h7777});
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b10;
        bus.req_rx    = 3'd5;
        bus.req_data  = 16'h7777;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        chk("wrst_pre_rd_wr", {63'd0, bus.rf_rd_wr}, 64'd1);
        chk("wrst_pre_reg_num", {61'd0, bus.rf_reg_num}, 64'd5);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("wrst_rd_wr", {63'd0, bus.rf_rd_wr}, 64'd0);
        chk("wrst_reg_num_held", {61'd0, bus.rf_reg_num}, 64'd5);
        chk("wrst_req_ready", {63'd0, bus.req_ready}, 64'd1);
        chk("wrst_rsp_out", {bus.rsp_valid, bus.rsp_err, bus.rsp_a, bus.rsp_b}, 64'd0);
        @(negedge clk);
        chk("wrst_reg_num_cleared", {61'd0, bus.rf_reg_num}, 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        sh[5] = 16'h7777;
        send(2'b00, 3'd3, 3'd0, 16'd0, 16'hBEEF, 16'd0, 1'b0, 2);
        wait_idle();

        // Random request stream with random response backpressure.
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    op = 2'($urandom_range(0, 3));
                    rx = 3'($urandom_range(0, 7));
                    ry = 3'($urandom_range(0, 7));
                    d  = 16'($urandom_range(0, 65535));
                    case (op)
                        2'b00: send(op, rx, ry, d, sh[rx], 16'd0, 1'b0, 2);
                        2'b01: send(op, rx, ry, d, sh[rx], sh[ry], 1'b0, 3);
                        2'b10: begin
                            send(op, rx, ry, d, d, 16'd0, 1'b0, 3);
                            sh[rx] = d;
                        end
                        default: send(op, rx, ry, d, 16'd0, 16'd0, 1'b1, 1);
                    endcase
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 bus.rsp_ready = ($urandom_range(0, 3) != 0);
                end
                bus.rsp_ready = 1'b1;
            end
        join
        wait_idle();
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
